// File: rtl/his_readout_pkg.sv
// ---------------------------------------------------------------------------
// his_readout_pkg
//
// Shared definitions for the histogram readout block:
//   - default geometry of the histogram RAM (bin address bits, count width,
//     pixels per RAM)
//   - the readout sweep state encoding
//   - a helper that sizes the pixel index field
//
// No ports; imported by his_readout and his_peak_tracker.
// ---------------------------------------------------------------------------
package his_readout_pkg;

    // Default geometry: 2^10 bins per pixel, 8-bit counts, 3 pixels per RAM
    localparam int NB_DEFAULT        = 10;
    localparam int PEAK_MAX_DEFAULT  = 8;
    localparam int PIXEL_NUM_DEFAULT = 3;

    // Readout sweep states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Pixel index width.  A single-pixel RAM still carries a 1-bit pixel
    // field so the address concatenation never has a zero-width part.
    function automatic int pix_width(input int pixel_num);
        if (pixel_num < 2) begin
            return 1;
        end
        return $clog2(pixel_num);
    endfunction

endpackage

// File: rtl/his_peak_tracker.sv
// ---------------------------------------------------------------------------
// his_peak_tracker
//
// Running maximum over one pixel's histogram as its bins stream past in
// ascending order.  Bin 0 always reloads the tracker, so no explicit clear
// is needed between pixels.  Later bins replace the stored peak only when
// their count is strictly greater, so on a tie the lowest bin index wins.
//
// Ports:
//   clk        in   clock, rising edge
//   res        in   asynchronous active-low reset
//   update     in   a new (bin, count) pair is presented this cycle
//   bin        in   NB        bin index of the presented count
//   count      in   PEAK_MAX  count of the presented bin
//   max_bin    out  NB        bin index of the largest count seen so far
//   max_count  out  PEAK_MAX  largest count seen so far
// ---------------------------------------------------------------------------
module his_peak_tracker
    import his_readout_pkg::*;
#(
    parameter int NB       = NB_DEFAULT,
    parameter int PEAK_MAX = PEAK_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                res,
    input  logic                update,
    input  logic [NB-1:0]       bin,
    input  logic [PEAK_MAX-1:0] count,
    output logic [NB-1:0]       max_bin,
    output logic [PEAK_MAX-1:0] max_count
);

    logic first_bin;
    logic take_new;

    // Bin 0 starts a fresh pixel; otherwise only a strictly larger count
    // displaces the stored peak, which keeps the earliest bin on ties.
    always_comb begin
        first_bin = (bin == '0);
        take_new  = update && (first_bin || (count > max_count));
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            max_bin   <= '0;
            max_count <= '0;
        end else if (take_new) begin
            max_bin   <= bin;
            max_count <= count;
        end
    end

endmodule

// File: rtl/his_readout.sv
// ---------------------------------------------------------------------------
// his_readout
//
// Reader side of the histogram SRAM filled during acquisition.  After start,
// it walks every pixel's histogram bin by bin through the single RAM port,
// streams (pixel, bin, count) words on a valid/ready interface and, when
// clear_en was set at start, writes zero back into each bin right after
// reading it so the RAM is ready for the next acquisition.  On the last bin
// of each pixel it also reports that pixel's peak bin and count.
//
// Each word costs three cycles: READ issues the RAM read, CAPT registers
// the returned data (and performs the optional clear write on the same
// address), SEND holds the word until the consumer accepts it.  Read and
// write are therefore never issued in the same cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   res         in   asynchronous active-low reset
//   start       in   one-cycle pulse; begins a sweep, only honoured in IDLE
//   clear_en    in   sampled with start; 1 = zero each bin after reading
//   busy        out  high from the cycle after start until DONE ends
//   done        out  one-cycle pulse when the sweep completes
//   ram_rd_en   out  RAM read strobe
//   ram_wr_en   out  RAM write strobe (clear)
//   ram_addr    out  ADDR_W    {pixel, bin}
//   ram_wdata   out  PEAK_MAX  always zero
//   ram_rdata   in   PEAK_MAX  read data, valid one cycle after ram_rd_en
//   out_valid   out  stream word valid
//   out_ready   in   downstream accept
//   out_pixel   out  PIX_W     pixel index of the word
//   out_bin     out  NB        bin index of the word
//   out_count   out  PEAK_MAX  bin count
//   out_last    out  word is the last bin of its pixel
//   peak_valid  out  one-cycle pulse after a pixel's last word is accepted
//   peak_bin    out  NB        bin holding that pixel's maximum count
//   peak_count  out  PEAK_MAX  that maximum count
// ---------------------------------------------------------------------------
module his_readout
    import his_readout_pkg::*;
#(
    parameter  int NB                = NB_DEFAULT,
    parameter  int PEAK_MAX          = PEAK_MAX_DEFAULT,
    parameter  int PIXEL_NUM_PER_RAM = PIXEL_NUM_DEFAULT,
    localparam int PIX_W             = pix_width(PIXEL_NUM_PER_RAM),
    localparam int ADDR_W            = PIX_W + NB
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                clear_en,
    output logic                busy,
    output logic                done,
    output logic                ram_rd_en,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [PEAK_MAX-1:0] ram_wdata,
    input  logic [PEAK_MAX-1:0] ram_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pixel,
    output logic [NB-1:0]       out_bin,
    output logic [PEAK_MAX-1:0] out_count,
    output logic                out_last,
    output logic                peak_valid,
    output logic [NB-1:0]       peak_bin,
    output logic [PEAK_MAX-1:0] peak_count
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [NB-1:0]    BIN_LAST = '1;

    state_t              state;
    logic                clear_lat;
    logic [PIX_W-1:0]    pixel_cnt;
    logic [NB-1:0]       bin_cnt;

    logic [PIX_W-1:0]    next_pix;
    logic [NB-1:0]       next_bin;
    logic                at_last_bin;
    logic                sweep_end;
    logic                handshake;

    logic                trk_update;
    logic [NB-1:0]       trk_bin;
    logic [PEAK_MAX-1:0] trk_count;

    // Clearing always writes zero; there is no other write source here.
    assign ram_wdata = '0;

    // Next sweep position: bins advance first, then the pixel on bin wrap.
    always_comb begin
        at_last_bin = (bin_cnt == BIN_LAST);
        sweep_end   = at_last_bin && (pixel_cnt == LAST_PIX);
        next_bin    = bin_cnt + NB'(1);
        next_pix    = pixel_cnt;
        if (at_last_bin) begin
            next_pix = pixel_cnt + PIX_W'(1);
        end
        handshake   = (state == ST_SEND) && out_ready;
        trk_update  = (state == ST_CAPT);
    end

    // The tracker sees each bin's count as it returns from the RAM, so by
    // the time the last bin sits in SEND its result is final.
    his_peak_tracker #(
        .NB       (NB),
        .PEAK_MAX (PEAK_MAX)
    ) u_peak_tracker (
        .clk       (clk),
        .res       (res),
        .update    (trk_update),
        .bin       (bin_cnt),
        .count     (ram_rdata),
        .max_bin   (trk_bin),
        .max_count (trk_count)
    );

    // Sweep sequencer.  Every strobe is registered on the transition into
    // the state that needs it, so the outputs line up with the state.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= ST_IDLE;
            clear_lat  <= 1'b0;
            pixel_cnt  <= '0;
            bin_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_rd_en  <= 1'b0;
            ram_wr_en  <= 1'b0;
            ram_addr   <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_bin    <= '0;
            out_count  <= '0;
            out_last   <= 1'b0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_count <= '0;
        end else begin
            done       <= 1'b0;
            peak_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        clear_lat <= clear_en;
                        pixel_cnt <= '0;
                        bin_cnt   <= '0;
                        ram_addr  <= '0;
                        ram_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_READ;
                    end
                end

                // Read is in flight; the clear write (if any) reuses the
                // address in the following cycle.
                ST_READ: begin
                    ram_rd_en <= 1'b0;
                    ram_wr_en <= clear_lat;
                    state     <= ST_CAPT;
                end

                ST_CAPT: begin
                    ram_wr_en <= 1'b0;
                    out_count <= ram_rdata;
                    out_pixel <= pixel_cnt;
                    out_bin   <= bin_cnt;
                    out_last  <= at_last_bin;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            peak_valid <= 1'b1;
                            peak_bin   <= trk_bin;
                            peak_count <= trk_count;
                        end
                        if (sweep_end) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pixel_cnt <= next_pix;
                            bin_cnt   <= next_bin;
                            ram_addr  <= {next_pix, next_bin};
                            ram_rd_en <= 1'b1;
                            state     <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
